// File: rtl/tx_hop_ramp.sv
// Per-hop IQ amplitude envelope: linear ramp up/down on tx_en,
// Q1.15 gain with rounding and saturation in a fixed 2-cycle pipeline.
module tx_hop_ramp #(
  parameter int DATA_WIDTH = 16,
  parameter int GAIN_WIDTH = 16,
  parameter int RAMP_STEP  = 128,
  parameter logic [GAIN_WIDTH-1:0] GAIN_MAX = 16'h8000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_i,
  input  logic [DATA_WIDTH-1:0] in_q,
  input  logic                  in_tvalid,
  input  logic                  tx_en,
  input  logic                  mute,
  input  logic [GAIN_WIDTH-1:0] gain_target,
  output logic [DATA_WIDTH-1:0] out_i,
  output logic [DATA_WIDTH-1:0] out_q,
  output logic                  out_tvalid,
  output logic [1:0]            ramp_state,
  output logic [GAIN_WIDTH-1:0] cur_gain,
  output logic                  ramp_done
);

  localparam int GW1  = GAIN_WIDTH + 1;
  localparam int PW   = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam int FRAC = GAIN_WIDTH - 1;

  localparam logic [GW1-1:0] STEP_W = GW1'(RAMP_STEP);
  localparam logic signed [PW-1:0] ONE =
    {{(PW-1){1'b0}}, 1'b1};
  localparam logic signed [PW-1:0] RND =
    ONE <<< (FRAC - 1);
  localparam logic signed [PW-1:0] MAXV =
    (ONE <<< (DATA_WIDTH - 1)) - ONE;
  localparam logic signed [PW-1:0] MINV =
    -(ONE <<< (DATA_WIDTH - 1));

  typedef enum logic [1:0] {
    OFF       = 2'b00,
    RAMP_UP   = 2'b01,
    ON        = 2'b10,
    RAMP_DOWN = 2'b11
  } state_t;

  state_t                state;
  logic [GAIN_WIDTH-1:0] tgt;
  logic [GAIN_WIDTH-1:0] tgt_clamp;
  logic [GW1-1:0]        up_sum;

  assign tgt_clamp = (gain_target > GAIN_MAX) ?
                     GAIN_MAX : gain_target;
  assign up_sum    = {1'b0, cur_gain} + STEP_W;
  assign ramp_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= OFF;
      cur_gain  <= '0;
      tgt       <= '0;
      ramp_done <= 1'b0;
    end else begin
      ramp_done <= 1'b0;
      if (mute) begin
        state    <= OFF;
        cur_gain <= '0;
      end else begin
        unique case (state)
          OFF: begin
            cur_gain <= '0;
            if (tx_en) begin
              state <= RAMP_UP;
              tgt   <= tgt_clamp;
            end
          end
          RAMP_UP: begin
            if (!tx_en) begin
              state <= RAMP_DOWN;
            end else if (up_sum >= {1'b0, tgt}) begin
              cur_gain  <= tgt;
              state     <= ON;
              ramp_done <= 1'b1;
            end else begin
              cur_gain <= up_sum[GAIN_WIDTH-1:0];
            end
          end
          ON: begin
            cur_gain <= tgt;
            if (!tx_en) state <= RAMP_DOWN;
          end
          RAMP_DOWN: begin
            if (tx_en) begin
              state <= RAMP_UP;
              tgt   <= tgt_clamp;
            end else if ({1'b0, cur_gain} <= STEP_W) begin
              cur_gain  <= '0;
              state     <= OFF;
              ramp_done <= 1'b1;
            end else begin
              cur_gain <= cur_gain - STEP_W[GAIN_WIDTH-1:0];
            end
          end
          default: state <= OFF;
        endcase
      end
    end
  end

  // Round-half-up then saturate to the signed sample range.
  function automatic logic [DATA_WIDTH-1:0] scale(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic [GAIN_WIDTH-1:0]        g
  );
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] r;
    p = PW'(x) * PW'($signed({1'b0, g}));
    r = (p + RND) >>> FRAC;
    if (r > MAXV)      scale = MAXV[DATA_WIDTH-1:0];
    else if (r < MINV) scale = MINV[DATA_WIDTH-1:0];
    else               scale = r[DATA_WIDTH-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] s1_i;
  logic [DATA_WIDTH-1:0] s1_q;
  logic                  s1_v;
  logic [GAIN_WIDTH-1:0] s1_gain;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_i       <= '0;
      s1_q       <= '0;
      s1_v       <= 1'b0;
      s1_gain    <= '0;
      out_i      <= '0;
      out_q      <= '0;
      out_tvalid <= 1'b0;
    end else begin
      s1_i       <= in_i;
      s1_q       <= in_q;
      s1_v       <= in_tvalid;
      s1_gain    <= cur_gain;
      out_i      <= scale(s1_i, s1_gain);
      out_q      <= scale(s1_q, s1_gain);
      out_tvalid <= s1_v;
    end
  end

endmodule

// File: tb/tb_tx_hop_ramp.sv
// Directed bench for tx_hop_ramp: envelope ramps, abort,
// clamp/rounding, mute, valid delay and mid-stream reset.
module tb_tx_hop_ramp;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_i;
  logic [15:0] in_q;
  logic        in_tvalid;
  logic        tx_en;
  logic        mute;
  logic [15:0] gain_target;
  logic [15:0] out_i;
  logic [15:0] out_q;
  logic        out_tvalid;
  logic [1:0]  ramp_state;
  logic [15:0] cur_gain;
  logic        ramp_done;

  int checks = 0;
  int errors = 0;

  tx_hop_ramp dut (
    .clk(clk),
    .reset(reset),
    .in_i(in_i),
    .in_q(in_q),
    .in_tvalid(in_tvalid),
    .tx_en(tx_en),
    .mute(mute),
    .gain_target(gain_target),
    .out_i(out_i),
    .out_q(out_q),
    .out_tvalid(out_tvalid),
    .ramp_state(ramp_state),
    .cur_gain(cur_gain),
    .ramp_done(ramp_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (ramp_state !== 2'b00 || cur_gain !== 16'd0 ||
        out_i !== 16'd0 || out_q !== 16'd0 ||
        out_tvalid !== 1'b0 || ramp_done !== 1'b0) begin
      errors++;
      $display("FAIL reset: st=%0d g=%0d oi=%0d oq=%0d v=%b d=%b want all 0",
               ramp_state, cur_gain, out_i, out_q, out_tvalid, ramp_done);
    end
    reset = 1'b0;
  endtask

  task automatic test_ramp_up();
    logic [15:0] eg;
    logic [1:0]  es;
    logic        ed;
    tx_en = 1'b1;
    gain_target = 16'h8000;
    in_i = 16'd16384;
    in_q = 16'd16384;
    in_tvalid = 1'b1;
    step();
    checks++;
    if (ramp_state !== 2'b01 || cur_gain !== 16'd0) begin
      errors++;
      $display("FAIL up_start: st=%0d g=%0d want 1/0",
               ramp_state, cur_gain);
    end
    for (int k = 1; k <= 256; k++) begin
      step();
      eg = 16'(128 * k);
      es = (k == 256) ? 2'b10 : 2'b01;
      ed = (k == 256);
      checks++;
      if (cur_gain !== eg || ramp_state !== es ||
          ramp_done !== ed) begin
        errors++;
        $display("FAIL up_k%0d: g=%0d st=%0d d=%b want %0d/%0d/%b",
                 k, cur_gain, ramp_state, ramp_done, eg, es, ed);
      end
    end
    step();
    checks++;
    if (ramp_state !== 2'b10 || ramp_done !== 1'b0 ||
        out_i !== 16'd16320) begin
      errors++;
      $display("FAIL up_on1: st=%0d d=%b oi=%0d want 2/0/16320",
               ramp_state, ramp_done, out_i);
    end
    step();
    checks++;
    if (out_i !== 16'd16384 || out_q !== 16'd16384) begin
      errors++;
      $display("FAIL up_full: oi=%0d oq=%0d want 16384",
               out_i, out_q);
    end
  endtask

  task automatic test_ramp_down();
    logic [15:0] eg;
    logic [1:0]  es;
    logic        ed;
    tx_en = 1'b0;
    step();
    checks++;
    if (ramp_state !== 2'b11 || cur_gain !== 16'd32768) begin
      errors++;
      $display("FAIL dn_start: st=%0d g=%0d want 3/32768",
               ramp_state, cur_gain);
    end
    for (int k = 1; k <= 256; k++) begin
      step();
      eg = 16'(32768 - 128 * k);
      es = (k == 256) ? 2'b00 : 2'b11;
      ed = (k == 256);
      checks++;
      if (cur_gain !== eg || ramp_state !== es ||
          ramp_done !== ed) begin
        errors++;
        $display("FAIL dn_k%0d: g=%0d st=%0d d=%b want %0d/%0d/%b",
                 k, cur_gain, ramp_state, ramp_done, eg, es, ed);
      end
    end
    step();
    step();
    checks++;
    if (out_i !== 16'd0 || ramp_done !== 1'b0 ||
        ramp_state !== 2'b00) begin
      errors++;
      $display("FAIL dn_settle: oi=%0d d=%b st=%0d want 0/0/0",
               out_i, ramp_done, ramp_state);
    end
  endtask

  task automatic test_abort();
    logic [15:0] eg;
    logic [1:0]  es;
    logic        ed;
    tx_en = 1'b1;
    step();
    for (int k = 1; k <= 8; k++) step();
    checks++;
    if (cur_gain !== 16'd1024 || ramp_state !== 2'b01) begin
      errors++;
      $display("FAIL ab_pre: g=%0d st=%0d want 1024/1",
               cur_gain, ramp_state);
    end
    tx_en = 1'b0;
    step();
    checks++;
    if (ramp_state !== 2'b11 || cur_gain !== 16'd1024 ||
        ramp_done !== 1'b0) begin
      errors++;
      $display("FAIL ab_turn: st=%0d g=%0d d=%b want 3/1024/0",
               ramp_state, cur_gain, ramp_done);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      eg = 16'(1024 - 128 * k);
      checks++;
      if (ramp_state !== 2'b11 || cur_gain !== eg) begin
        errors++;
        $display("FAIL ab_dn%0d: st=%0d g=%0d want 3/%0d",
                 k, ramp_state, cur_gain, eg);
      end
    end
    tx_en = 1'b1;
    gain_target = 16'h4000;
    step();
    checks++;
    if (ramp_state !== 2'b01 || cur_gain !== 16'd512) begin
      errors++;
      $display("FAIL ab_reup: st=%0d g=%0d want 1/512",
               ramp_state, cur_gain);
    end
    for (int k = 1; k <= 124; k++) begin
      step();
      eg = 16'(512 + 128 * k);
      es = (k == 124) ? 2'b10 : 2'b01;
      ed = (k == 124);
      checks++;
      if (cur_gain !== eg || ramp_state !== es ||
          ramp_done !== ed) begin
        errors++;
        $display("FAIL ab_up%0d: g=%0d st=%0d d=%b want %0d/%0d/%b",
                 k, cur_gain, ramp_state, ramp_done, eg, es, ed);
      end
    end
  endtask

  task automatic test_clamp_round();
    mute = 1'b1;
    gain_target = 16'hFFFF;
    step();
    mute = 1'b0;
    step();
    for (int k = 1; k <= 256; k++) step();
    checks++;
    if (cur_gain !== 16'h8000 || ramp_state !== 2'b10) begin
      errors++;
      $display("FAIL clamp: g=%0h st=%0d want 8000/2",
               cur_gain, ramp_state);
    end
    in_i = 16'h8000;
    in_q = 16'h7FFF;
    step();
    step();
    checks++;
    if (out_i !== 16'h8000 || out_q !== 16'h7FFF) begin
      errors++;
      $display("FAIL fullscale: oi=%0h oq=%0h want 8000/7fff",
               out_i, out_q);
    end
    mute = 1'b1;
    gain_target = 16'h4000;
    step();
    mute = 1'b0;
    step();
    for (int k = 1; k <= 128; k++) step();
    checks++;
    if (cur_gain !== 16'h4000 || ramp_state !== 2'b10) begin
      errors++;
      $display("FAIL half_on: g=%0h st=%0d want 4000/2",
               cur_gain, ramp_state);
    end
    in_i = 16'd3;
    in_q = 16'hFFFD;
    step();
    step();
    checks++;
    if (out_i !== 16'd2 || out_q !== 16'hFFFF) begin
      errors++;
      $display("FAIL round: oi=%0h oq=%0h want 0002/ffff",
               out_i, out_q);
    end
  endtask

  task automatic test_mute();
    mute = 1'b1;
    gain_target = 16'h8000;
    step();
    mute = 1'b0;
    in_i = 16'd16384;
    in_q = 16'd16384;
    step();
    for (int k = 1; k <= 16; k++) step();
    checks++;
    if (cur_gain !== 16'd2048 || ramp_state !== 2'b01) begin
      errors++;
      $display("FAIL mute_pre: g=%0d st=%0d want 2048/1",
               cur_gain, ramp_state);
    end
    mute = 1'b1;
    step();
    checks++;
    if (ramp_state !== 2'b00 || cur_gain !== 16'd0 ||
        ramp_done !== 1'b0) begin
      errors++;
      $display("FAIL mute: st=%0d g=%0d d=%b want 0/0/0",
               ramp_state, cur_gain, ramp_done);
    end
    mute = 1'b0;
    step();
    checks++;
    if (ramp_state !== 2'b01 || cur_gain !== 16'd0) begin
      errors++;
      $display("FAIL mute_rel: st=%0d g=%0d want 1/0",
               ramp_state, cur_gain);
    end
    step();
    checks++;
    if (cur_gain !== 16'd128) begin
      errors++;
      $display("FAIL mute_restart: g=%0d want 128", cur_gain);
    end
  endtask

  task automatic test_tvalid_reset();
    logic [3:0] pat;
    pat = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      in_tvalid = (i < 4) ? pat[i] : 1'b1;
      step();
      if (i >= 1) begin
        checks++;
        if (out_tvalid !== pat[i-1]) begin
          errors++;
          $display("FAIL tvalid_%0d: got %b want %b",
                   i - 1, out_tvalid, pat[i-1]);
        end
      end
    end
    step();
    step();
    checks++;
    if (out_tvalid !== 1'b1 || out_i === 16'd0) begin
      errors++;
      $display("FAIL pre_rst: v=%b oi=%0d want 1/nonzero",
               out_tvalid, out_i);
    end
    reset = 1'b1;
    step();
    checks++;
    if (out_tvalid !== 1'b0 || out_i !== 16'd0 ||
        out_q !== 16'd0 || ramp_state !== 2'b00 ||
        cur_gain !== 16'd0) begin
      errors++;
      $display("FAIL mid_rst: v=%b oi=%0d oq=%0d st=%0d g=%0d want 0",
               out_tvalid, out_i, out_q, ramp_state, cur_gain);
    end
    reset = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1;
    in_i = '0;
    in_q = '0;
    in_tvalid = 1'b0;
    tx_en = 1'b0;
    mute = 1'b0;
    gain_target = '0;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_abort();
    test_clamp_round();
    test_mute();
    test_tvalid_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_hop_ramp.md
Name: tx_hop_ramp

Overview:
- Per-hop amplitude envelope stage sitting directly downstream of the tag-chip multitone transmit controller's itx/qtx outputs, in front of the radio TX datapath.
- Ramps the IQ amplitude linearly up when transmission is enabled and down when it is disabled, which suppresses spectral splatter at the hard zero-gating between hop-sync gaps and hop transmissions.
- Applies a programmable Q1.15 gain with rounding and saturation in a fixed 2-cycle pipeline.

Parameters:
DATA_WIDTH, 16, signed I/Q sample width
GAIN_WIDTH, 16, unsigned gain width, Q1.15 (0x8000 = 1.0)
RAMP_STEP, 128, gain increment/decrement per clock while ramping (must be >0)
GAIN_MAX, 16'h8000, clamp ceiling applied to gain_target

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
in_i  in  DATA_WIDTH  signed I sample from controller
in_q  in  DATA_WIDTH  signed Q sample from controller
in_tvalid  in  1  input sample qualifier
tx_en  in  1  level; 1 = transmit window (ramp up/hold), 0 = gap (ramp down/off)
mute  in  1  synchronous force-off, overrides tx_en
gain_target  in  GAIN_WIDTH  hold gain, Q1.15, latched at ramp-up start
out_i  out  DATA_WIDTH  scaled I
out_q  out  DATA_WIDTH  scaled Q
out_tvalid  out  1  in_tvalid delayed 2 clocks
ramp_state  out  2  OFF=00, RAMP_UP=01, ON=10, RAMP_DOWN=11
cur_gain  out  GAIN_WIDTH  current envelope gain register
ramp_done  out  1  one-cycle pulse on entering ON or OFF from a ramp

Behaviour:
- Clock domain and reset: single clock clk. Reset is synchronous and active-high.
- Reset values: state OFF, cur_gain 0, latched target 0. out_i/out_q 0, out_tvalid 0, ramp_done 0. Both pipeline stages are cleared.
- Priority in each cycle: reset > mute > state machine.
- mute=1: state<=OFF, cur_gain<=0 next edge, ramp_done not asserted. Pipeline samples already in flight still drain with the gain they were captured with.
- OFF:
  - If tx_en=1: state<=RAMP_UP, tgt<=min(gain_target, GAIN_MAX).
  - cur_gain holds 0.
- RAMP_UP:
  - If tx_en=0: state<=RAMP_DOWN, cur_gain unchanged.
  - Else if cur_gain+RAMP_STEP >= tgt: cur_gain<=tgt, state<=ON, ramp_done<=1.
  - Else cur_gain<=cur_gain+RAMP_STEP.
  - Compare at GAIN_WIDTH+1 bits; no wrap allowed.
- ON:
  - cur_gain holds tgt; gain_target changes are ignored until the next ramp-up.
  - If tx_en=0: state<=RAMP_DOWN.
- RAMP_DOWN:
  - If tx_en=1: state<=RAMP_UP, tgt re-latched from gain_target, cur_gain unchanged.
  - Else if cur_gain <= RAMP_STEP: cur_gain<=0, state<=OFF, ramp_done<=1.
  - Else cur_gain<=cur_gain-RAMP_STEP.
- tgt=0 on ramp-up: the next RAMP_UP cycle enters ON with gain 0 and pulses ramp_done.
- Gain compute pipeline:
  - Stage 1 registers in_i, in_q, in_tvalid and the current cur_gain (the pre-update value of that edge).
  - Stage 2 computes p = s1_x * {1'b0,s1_gain} (signed, 2*DATA_WIDTH+1 bits), r = (p + 2^14) >>> 15 (arithmetic). r is saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and registered to out_i/out_q.
  - Stage 2 registers s1_tvalid to out_tvalid.
- Latency: exactly 2 clocks from input to output, every cycle. There is no backpressure.
- Invalid samples: when in_tvalid=0, samples are still scaled and passed through; out_tvalid=0 marks them.
- The envelope advances every clock regardless of in_tvalid.
- Full-scale check: with gain 0x8000, out equals in exactly (-32768 in gives -32768 out, 32767 in gives 32767 out).
- Reset mid-ramp: immediate OFF, gain 0, and outputs are zero on the following edge.

Test Plan:
- Reset, then tx_en=1, gain_target=0x8000, in_i=in_q=16384 constant. Required: RAMP_UP the edge after tx_en is sampled; cur_gain 128, 256, … 32640; 32768 on the 256th RAMP_UP edge; ON; single ramp_done pulse; out_i reaches 16384 two clocks after cur_gain=0x8000.
- From ON (gain 0x8000), drop tx_en. Required: RAMP_DOWN with cur_gain 32640 … 128, then 0 and OFF after 256 edges; ramp_done pulse; out settles to 0.
- Raise tx_en, then drop it when cur_gain=1024. Required: next state RAMP_DOWN, gain 896, 768, …, then 0 with no ON visit. Re-raise tx_en at gain 512 with gain_target=0x4000. Required: ramps up to 0x4000 and enters ON.
- gain_target=0xFFFF at ramp start. Required: clamped to 0x8000. With in_i=-32768 at full gain, out_i=-32768. in_i=3 at gain 0x4000 rounds to 2; in_i=-3 rounds to -1.
- mute=1 during RAMP_UP at gain 2048. Required: OFF, cur_gain 0 next edge, no ramp_done. tx_en held 1 after mute release restarts from 0.
- Toggle in_tvalid pattern 1,0,1,1. Required: out_tvalid shows 1,0,1,1 delayed exactly 2 clocks. Synchronous reset asserted mid-stream clears out_tvalid and out_i/out_q to 0 the next edge.
